// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state and forwarding encodings for the pipeline hazard control.
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {RUN, IWAIT, DWAIT} hz_state_t;
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: EX-stage operand bypass selects; Memory result beats Writeback result.
module forward_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
)(
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);
   function automatic logic [1:0] sel(input logic [REG_AW-1:0] rs);
      return (reg_write_m && rd_m != '0 && rd_m == rs) ? FWD_MEM :
             (reg_write_w && rd_w != '0 && rd_w == rs) ? FWD_WB  : FWD_RF;
   endfunction
   always_comb begin
      fwd_a = sel(rs1);
      fwd_b = sel(rs2);
   end
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush sequencing and EX forwarding selects.
// Define HAZARD_PERF_EN to add the StallCycles/FlushCount performance counters.
module hazard_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
`ifdef HAZARD_PERF_EN
   , parameter int CNT_W = 32
`endif
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic [REG_AW-1:0] RdE,
   input  logic              LoadE,
   input  logic [REG_AW-1:0] RdM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              PCSrcE,
   input  logic              JALRinstrE,
   input  logic              IMissF,
   input  logic              IFillDone,
   input  logic              DMissM,
   input  logic              DFillDone,
   output logic              PCEnF,
   output logic              StallD,
   output logic              FlushD,
   output logic              StallE,
   output logic              FlushE,
   output logic              StallM,
   output logic              FlushW,
   output logic              IAbortF,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE
`ifdef HAZARD_PERF_EN
   , output logic [CNT_W-1:0] StallCycles
   , output logic [CNT_W-1:0] FlushCount
`endif
);
   hz_state_t state, next_state;
   logic redirect, dmiss, imiss, load_use;
   logic [1:0] fwd_a, fwd_b;

   assign redirect = PCSrcE | JALRinstrE;
   assign dmiss    = (state == RUN && DMissM) || (state == DWAIT && !DFillDone);
   assign imiss    = (state == RUN && IMissF) || (state == IWAIT && !IFillDone);
   assign load_use = state == RUN && LoadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);

   forward_unit #(.REG_AW(REG_AW)) u_fwd (
      .rs1(Rs1E), .rs2(Rs2E), .rd_m(RdM), .rd_w(RdW),
      .reg_write_m(RegWriteM), .reg_write_w(RegWriteW),
      .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   assign ForwardAE = reset ? FWD_RF : fwd_a;
   assign ForwardBE = reset ? FWD_RF : fwd_b;

   always_ff @(posedge clk)
      state <= reset ? RUN : next_state;

   // Every resolved case returns to RUN unless it is (still) waiting on a fill.
   always_comb begin
      PCEnF      = 1'b1;
      StallD     = 1'b0;
      FlushD     = 1'b0;
      StallE     = 1'b0;
      FlushE     = 1'b0;
      StallM     = 1'b0;
      FlushW     = 1'b0;
      IAbortF    = 1'b0;
      next_state = RUN;
      if (reset) begin
         PCEnF  = 1'b0;
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else if (dmiss) begin
         PCEnF      = 1'b0;
         StallD     = 1'b1;
         StallE     = 1'b1;
         StallM     = 1'b1;
         FlushW     = 1'b1;
         next_state = DWAIT;
      end else if (redirect) begin
         FlushD  = 1'b1;
         FlushE  = 1'b1;
         IAbortF = state == IWAIT;
      end else if (imiss) begin
         PCEnF      = 1'b0;
         StallD     = 1'b1;
         FlushE     = 1'b1;
         next_state = IWAIT;
      end else if (load_use) begin
         PCEnF  = 1'b0;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   // Outside reset FlushD is raised only by a redirect.
   always_ff @(posedge clk)
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!PCEnF) stall_cnt <= stall_cnt + CNT_W'(1);
         if (FlushD) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   assign StallCycles = reset ? '0 : stall_cnt;
   assign FlushCount  = reset ? '0 : flush_cnt;
`endif
endmodule
